axi4lite_regfile_slave: RTL and testbench

//  Parametrised AXI4-Lite slave: a register file of NUM_REGS words with byte strobes, SLVERR decode and

---
 rtl/axi4lite_pkg.sv | 19 +
 rtl/axi4lite_regfile_slave.sv | 200 ++++++++++++++++++++
 tb/tb_axi4lite_regfile_slave.sv | 318 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/axi4lite_pkg.sv
// Shared AXI4-Lite definitions used by the register-file slave and its matching master.
// Response codes, strobe-width helper and the read-channel state encoding.
package axi4lite_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    localparam int AXI_DATA_WIDTH = 32;

    function automatic int strb_width(input int data_width);
        return data_width / 8;
    endfunction

    typedef enum logic {
        R_IDLE = 1'b0,
        R_DATA = 1'b1
    } r_state_e;

endpackage

// File: rtl/axi4lite_regfile_slave.sv
// AXI4-Lite slave exposing NUM_REGS byte-strobed registers with independent AW/W/AR channels,
// SLVERR on unimplemented words, flat register export and per-register write pulses.
module axi4lite_regfile_slave
    import axi4lite_pkg::*;
#(
    parameter int                    ADDR_WIDTH = 4,
    parameter int                    DATA_WIDTH = AXI_DATA_WIDTH,
    parameter int                    NUM_REGS   = 4,
    parameter logic [DATA_WIDTH-1:0] RESET_VAL  = '0,
    localparam int                   STRB_W     = strb_width(DATA_WIDTH)
) (
    input  logic                           s_axi_aclk,
    input  logic                           s_axi_aresetn,
    input  logic [ADDR_WIDTH-1:0]          s_axi_awaddr,
    input  logic                           s_axi_awvalid,
    output logic                           s_axi_awready,
    input  logic [DATA_WIDTH-1:0]          s_axi_wdata,
    input  logic [STRB_W-1:0]              s_axi_wstrb,
    input  logic                           s_axi_wvalid,
    output logic                           s_axi_wready,
    output logic [1:0]                     s_axi_bresp,
    output logic                           s_axi_bvalid,
    input  logic                           s_axi_bready,
    input  logic [ADDR_WIDTH-1:0]          s_axi_araddr,
    input  logic                           s_axi_arvalid,
    output logic                           s_axi_arready,
    output logic [DATA_WIDTH-1:0]          s_axi_rdata,
    output logic [1:0]                     s_axi_rresp,
    output logic                           s_axi_rvalid,
    input  logic                           s_axi_rready,
    output logic [NUM_REGS*DATA_WIDTH-1:0] reg_q,
    output logic [NUM_REGS-1:0]            reg_wr_pulse
);

    localparam int IDX_W = ADDR_WIDTH - 2;

    // Byte-offset bits never take part in decode.
    logic unused_addr_lsbs;
    assign unused_addr_lsbs = ^{s_axi_awaddr[1:0], s_axi_araddr[1:0]};

    // ------------------------------------------------------------------
    // Write channel holding registers and response
    // ------------------------------------------------------------------
    logic                  ready_en_reg;
    logic                  aw_full_reg;
    logic                  w_full_reg;
    logic [IDX_W-1:0]      aw_idx_reg;
    logic [DATA_WIDTH-1:0] w_data_reg;
    logic [STRB_W-1:0]     w_strb_reg;
    logic                  bvalid_reg;
    logic [1:0]            bresp_reg;
    logic [NUM_REGS-1:0]   wr_pulse_reg;

    logic                  aw_hs;
    logic                  w_hs;
    logic                  commit;
    logic                  aw_in_range;
    logic [NUM_REGS-1:0]   wr_en;

    assign s_axi_awready = ready_en_reg & ~aw_full_reg;
    assign s_axi_wready  = ready_en_reg & ~w_full_reg;
    assign aw_hs         = s_axi_awvalid & s_axi_awready;
    assign w_hs          = s_axi_wvalid & s_axi_wready;
    assign commit        = aw_full_reg & w_full_reg & ~bvalid_reg;
    assign aw_in_range   = 32'(aw_idx_reg) < 32'(NUM_REGS);

    always_ff @(posedge s_axi_aclk) begin
        if (!s_axi_aresetn) begin
            ready_en_reg <= 1'b0;
            aw_full_reg  <= 1'b0;
            w_full_reg   <= 1'b0;
            aw_idx_reg   <= '0;
            w_data_reg   <= '0;
            w_strb_reg   <= '0;
            bvalid_reg   <= 1'b0;
            bresp_reg    <= RESP_OKAY;
            wr_pulse_reg <= '0;
        end else begin
            ready_en_reg <= 1'b1;
            wr_pulse_reg <= wr_en;

            if (aw_hs) begin
                aw_full_reg <= 1'b1;
                aw_idx_reg  <= s_axi_awaddr[ADDR_WIDTH-1:2];
            end
            if (w_hs) begin
                w_full_reg <= 1'b1;
                w_data_reg <= s_axi_wdata;
                w_strb_reg <= s_axi_wstrb;
            end

            if (s_axi_bready && bvalid_reg) begin
                bvalid_reg <= 1'b0;
            end

            // Commit is gated by !bvalid, so it never collides with the B clear above.
            if (commit) begin
                bvalid_reg  <= 1'b1;
                bresp_reg   <= aw_in_range ? RESP_OKAY : RESP_SLVERR;
                aw_full_reg <= 1'b0;
                w_full_reg  <= 1'b0;
            end
        end
    end

    assign s_axi_bvalid = bvalid_reg;
    assign s_axi_bresp  = bresp_reg;
    assign reg_wr_pulse = wr_pulse_reg;

    // ------------------------------------------------------------------
    // Register storage with per-byte merge
    // ------------------------------------------------------------------
    genvar gi;
    generate
        for (gi = 0; gi < NUM_REGS; gi++) begin : g_reg
            logic [DATA_WIDTH-1:0] word_reg;

            assign wr_en[gi] = commit & aw_in_range & (32'(aw_idx_reg) == 32'(gi));

            always_ff @(posedge s_axi_aclk) begin
                if (!s_axi_aresetn) begin
                    word_reg <= RESET_VAL;
                end else if (wr_en[gi]) begin
                    for (int b = 0; b < STRB_W; b++) begin
                        if (w_strb_reg[b]) begin
                            word_reg[b*8 +: 8] <= w_data_reg[b*8 +: 8];
                        end
                    end
                end
            end

            assign reg_q[gi*DATA_WIDTH +: DATA_WIDTH] = word_reg;
        end
    endgenerate

    // ------------------------------------------------------------------
    // Read channel
    // ------------------------------------------------------------------
    r_state_e              r_state_reg;
    logic                  arready_reg;
    logic                  rvalid_reg;
    logic [DATA_WIDTH-1:0] rdata_reg;
    logic [1:0]            rresp_reg;

    logic [IDX_W-1:0]      ar_idx;
    logic                  ar_in_range;
    logic [DATA_WIDTH-1:0] rd_word;

    assign ar_idx      = s_axi_araddr[ADDR_WIDTH-1:2];
    assign ar_in_range = 32'(ar_idx) < 32'(NUM_REGS);

    // Reads the flops as they stand, so a same-cycle write is not yet visible.
    always_comb begin
        rd_word = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (32'(ar_idx) == 32'(i)) begin
                rd_word = reg_q[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    always_ff @(posedge s_axi_aclk) begin
        if (!s_axi_aresetn) begin
            r_state_reg <= R_IDLE;
            arready_reg <= 1'b0;
            rvalid_reg  <= 1'b0;
            rdata_reg   <= '0;
            rresp_reg   <= RESP_OKAY;
        end else begin
            case (r_state_reg)
                R_IDLE: begin
                    arready_reg <= 1'b1;
                    if (arready_reg && s_axi_arvalid) begin
                        rdata_reg   <= ar_in_range ? rd_word : '0;
                        rresp_reg   <= ar_in_range ? RESP_OKAY : RESP_SLVERR;
                        rvalid_reg  <= 1'b1;
                        arready_reg <= 1'b0;
                        r_state_reg <= R_DATA;
                    end
                end
                R_DATA: begin
                    if (s_axi_rready) begin
                        rvalid_reg  <= 1'b0;
                        arready_reg <= 1'b1;
                        r_state_reg <= R_IDLE;
                    end
                end
                default: begin
                    r_state_reg <= R_IDLE;
                end
            endcase
        end
    end

    assign s_axi_arready = arready_reg;
    assign s_axi_rvalid  = rvalid_reg;
    assign s_axi_rdata   = rdata_reg;
    assign s_axi_rresp   = rresp_reg;

endmodule

// File: tb/tb_axi4lite_regfile_slave.sv
// Randomised bench for axi4lite_regfile_slave (3 registers, 4-bit address) against an
// array-based model of the register file and its response rules.
module tb_axi4lite_regfile_slave;
    import axi4lite_pkg::*;

    localparam int AW = 4;
    localparam int DW = 32;
    localparam int NR = 3;

    logic              clk = 1'b0;
    logic              aresetn = 1'b0;
    logic [AW-1:0]     awaddr = '0;
    logic              awvalid = 1'b0;
    logic              awready;
    logic [DW-1:0]     wdata = '0;
    logic [3:0]        wstrb = '0;
    logic              wvalid = 1'b0;
    logic              wready;
    logic [1:0]        bresp;
    logic              bvalid;
    logic              bready = 1'b1;
    logic [AW-1:0]     araddr = '0;
    logic              arvalid = 1'b0;
    logic              arready;
    logic [DW-1:0]     rdata;
    logic [1:0]        rresp;
    logic              rvalid;
    logic              rready = 1'b0;
    logic [NR*DW-1:0]  reg_q;
    logic [NR-1:0]     reg_wr_pulse;

    always #5 clk = ~clk;

    axi4lite_regfile_slave #(
        .ADDR_WIDTH(AW),
        .DATA_WIDTH(DW),
        .NUM_REGS  (NR),
        .RESET_VAL (32'h0)
    ) dut (
        .s_axi_aclk   (clk),
        .s_axi_aresetn(aresetn),
        .s_axi_awaddr (awaddr),
        .s_axi_awvalid(awvalid),
        .s_axi_awready(awready),
        .s_axi_wdata  (wdata),
        .s_axi_wstrb  (wstrb),
        .s_axi_wvalid (wvalid),
        .s_axi_wready (wready),
        .s_axi_bresp  (bresp),
        .s_axi_bvalid (bvalid),
        .s_axi_bready (bready),
        .s_axi_araddr (araddr),
        .s_axi_arvalid(arvalid),
        .s_axi_arready(arready),
        .s_axi_rdata  (rdata),
        .s_axi_rresp  (rresp),
        .s_axi_rvalid (rvalid),
        .s_axi_rready (rready),
        .reg_q        (reg_q),
        .reg_wr_pulse (reg_wr_pulse)
    );

    int          n_vec = 0;
    int          n_err = 0;
    logic [31:0] model [NR];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: observed %08h required %08h", tag, obs, exp);
        end
    endtask

    // Reference: word index = addr/4; words beyond NR are errors and never stored.
    task automatic model_write(input logic [3:0] addr, input logic [31:0] data, input logic [3:0] strb,
                               output logic [1:0] resp, output logic [NR-1:0] pulse);
        int idx;
        idx   = int'(addr) / 4;
        pulse = '0;
        resp  = RESP_SLVERR;
        if (idx < NR) begin
            resp       = RESP_OKAY;
            pulse[idx] = 1'b1;
            for (int b = 0; b < 4; b++)
                if (strb[b]) model[idx][8*b +: 8] = data[8*b +: 8];
        end
    endtask

    task automatic model_read(input logic [3:0] addr, output logic [31:0] data, output logic [1:0] resp);
        int idx;
        idx  = int'(addr) / 4;
        data = 32'h0;
        resp = RESP_SLVERR;
        if (idx < NR) begin
            data = model[idx];
            resp = RESP_OKAY;
        end
    endtask

    task automatic check_regs(input string tag);
        for (int i = 0; i < NR; i++)
            check($sformatf("%s.reg_q[%0d]", tag, i), reg_q[i*DW +: DW], model[i]);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, ".awready"}, awready, 0);
        check({tag, ".wready"},  wready,  0);
        check({tag, ".arready"}, arready, 0);
        check({tag, ".bvalid"},  bvalid,  0);
        check({tag, ".bresp"},   bresp,   0);
        check({tag, ".rvalid"},  rvalid,  0);
        check({tag, ".rresp"},   rresp,   0);
        check({tag, ".rdata"},   rdata,   0);
        check({tag, ".pulse"},   reg_wr_pulse, 0);
        check_regs(tag);
    endtask

    // Drives AW and W starting at independent cycle offsets; returns #1 after the later handshake edge.
    task automatic send_aw_w(input logic [3:0] addr, input logic [31:0] data, input logic [3:0] strb,
                             input int aw_delay, input int w_delay);
        bit aw_done, w_done, aw_rdy, w_rdy;
        aw_done = 0;
        w_done  = 0;
        for (int c = 0; c < 60 && !(aw_done && w_done); c++) begin
            if (!aw_done && c == aw_delay) begin awaddr = addr; awvalid = 1'b1; end
            if (!w_done && c == w_delay) begin wdata = data; wstrb = strb; wvalid = 1'b1; end
            aw_rdy = awready;
            w_rdy  = wready;
            @(posedge clk); #1;
            if (awvalid && aw_rdy) begin aw_done = 1; awvalid = 1'b0; end
            if (wvalid && w_rdy)   begin w_done = 1;  wvalid = 1'b0; end
        end
        awvalid = 1'b0;
        wvalid  = 1'b0;
        check("aw_w_handshake", {aw_done, w_done}, 2'b11);
    endtask

    task automatic wait_bvalid(output int lat);
        lat = 0;
        while (!bvalid && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        check("bvalid_seen", bvalid, 1);
    endtask

    task automatic axi_write(input logic [3:0] addr, input logic [31:0] data, input logic [3:0] strb,
                             input int aw_delay, input int w_delay);
        logic [1:0]    er;
        logic [NR-1:0] ep;
        int            lat;
        send_aw_w(addr, data, strb, aw_delay, w_delay);
        wait_bvalid(lat);
        check("b_latency", lat, 1);
        model_write(addr, data, strb, er, ep);
        check("bresp", bresp, er);
        check("wr_pulse", reg_wr_pulse, ep);
        check_regs("wr");
        @(posedge clk); #1;
        check("bvalid_clr", bvalid, 0);
        check("wr_pulse_clr", reg_wr_pulse, 0);
        $display("WR addr=%h data=%08h strb=%b aw_dly=%0d w_dly=%0d bresp=%b", addr, data, strb,
                 aw_delay, w_delay, er);
    endtask

    task automatic axi_read(input logic [3:0] addr, input int rdelay);
        logic [31:0] ed;
        logic [1:0]  er;
        bit          rdy;
        araddr  = addr;
        arvalid = 1'b1;
        rdy     = 0;
        for (int c = 0; c < 20 && !rdy; c++) begin
            rdy = arready;
            @(posedge clk); #1;
        end
        arvalid = 1'b0;
        check("ar_handshake", rdy, 1);
        model_read(addr, ed, er);
        check("rvalid", rvalid, 1);
        check("rdata", rdata, ed);
        check("rresp", rresp, er);
        for (int d = 0; d < rdelay; d++) begin
            @(posedge clk); #1;
            check("rvalid_hold", rvalid, 1);
            check("rdata_hold", rdata, ed);
            check("rresp_hold", rresp, er);
        end
        rready = 1'b1;
        @(posedge clk); #1;
        rready = 1'b0;
        check("rvalid_clr", rvalid, 0);
        check("arready_back", arready, 1);
        $display("RD addr=%h rdata=%08h rresp=%b rready_dly=%0d", addr, ed, er, rdelay);
    endtask

    initial begin
        int            lat;
        logic [1:0]    er;
        logic [NR-1:0] ep;

        for (int i = 0; i < NR; i++) model[i] = 32'h0;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("rst");
        aresetn = 1'b1;
        check("rst_hold.awready", awready, 0);
        @(posedge clk); #1;
        check("rst_rel.awready", awready, 1);
        check("rst_rel.wready",  wready,  1);
        check("rst_rel.arready", arready, 1);

        // Full word to reg1, AW and W together
        axi_write(4'h4, 32'hDEADBEEF, 4'hF, 0, 0);
        // W well ahead of AW, partial strobes
        axi_write(4'h4, 32'h11223344, 4'b0101, 5, 0);
        check("t2.reg1", reg_q[1*DW +: DW], 32'hDE22BE44);
        // Unimplemented word 3
        axi_write(4'hC, 32'h12345678, 4'hF, 0, 2);
        axi_read(4'hC, 1);

        // Read of reg0 on the same edge that a write to reg0 commits
        awaddr = 4'h0; awvalid = 1'b1; wdata = 32'h000000A5; wstrb = 4'hF; wvalid = 1'b1;
        check("t5.aw_w_ready", {awready, wready}, 2'b11);
        @(posedge clk); #1;
        awvalid = 1'b0; wvalid = 1'b0;
        araddr = 4'h1; arvalid = 1'b1;
        check("t5.arready", arready, 1);
        @(posedge clk); #1;
        arvalid = 1'b0;
        check("t5.rvalid", rvalid, 1);
        check("t5.rdata_old", rdata, 32'h0);
        check("t5.bvalid", bvalid, 1);
        model_write(4'h0, 32'h000000A5, 4'hF, er, ep);
        check_regs("t5");
        $display("WR+RD same-edge reg0 new=000000a5 read=%08h", rdata);
        rready = 1'b1;
        @(posedge clk); #1;
        rready = 1'b0;
        axi_read(4'h0, 0);

        // Zero strobe still acknowledges and pulses
        axi_write(4'h9, 32'hFFFFFFFF, 4'h0, 1, 0);

        // Random traffic
        for (int n = 0; n < 30; n++) begin
            if ($urandom_range(0, 1) == 1)
                axi_write(4'($urandom_range(0, 15)), $urandom, 4'($urandom_range(0, 15)),
                          $urandom_range(0, 3), $urandom_range(0, 3));
            else
                axi_read(4'($urandom_range(0, 15)), $urandom_range(0, 3));
        end

        // Back-pressured B with a second write queued behind it
        bready = 1'b0;
        send_aw_w(4'hC, 32'h0BAD0BAD, 4'hF, 0, 0);
        wait_bvalid(lat);
        model_write(4'hC, 32'h0BAD0BAD, 4'hF, er, ep);
        check("t4.bresp1", bresp, er);
        send_aw_w(4'h8, 32'hCAFEF00D, 4'h3, 0, 1);
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            check("t4.bvalid_hold", bvalid, 1);
            check("t4.bresp_hold", bresp, er);
            check("t4.reg2_hold", reg_q[2*DW +: DW], model[2]);
        end
        bready = 1'b1;
        @(posedge clk); #1;
        check("t4.b_gap", bvalid, 0);
        @(posedge clk); #1;
        model_write(4'h8, 32'hCAFEF00D, 4'h3, er, ep);
        check("t4.bvalid2", bvalid, 1);
        check("t4.bresp2", bresp, er);
        check("t4.pulse2", reg_wr_pulse, ep);
        check_regs("t4");
        $display("WR queued behind held B: addr=8 data=cafef00d strb=0011 bresp=%b", er);
        @(posedge clk); #1;
        check("t4.bvalid_clr", bvalid, 0);

        // Reset with AW captured, W missing and a read response pending
        awaddr = 4'h8; awvalid = 1'b1;
        @(posedge clk); #1;
        awvalid = 1'b0;
        araddr = 4'h4; arvalid = 1'b1;
        @(posedge clk); #1;
        arvalid = 1'b0;
        check("t6.rvalid_pre", rvalid, 1);
        check("t6.awready_pre", awready, 0);
        aresetn = 1'b0;
        @(posedge clk); #1;
        for (int i = 0; i < NR; i++) model[i] = 32'h0;
        check_reset_outputs("t6");
        aresetn = 1'b1;
        @(posedge clk); #1;
        check("t6.awready_post", awready, 1);
        wdata = 32'h5A5A5A5A; wstrb = 4'hF; wvalid = 1'b1;
        @(posedge clk); #1;
        wvalid = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        check("t6.no_commit", bvalid, 0);
        check_regs("t6");
        $display("RST mid-transaction: dropped AW, lone W held, no commit");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule
